evt_change_logger: RTL

Sequential event-capture stage that watches a small bus of design signals, detects every cycle on which any bit changes, and records the new value, a per-bit change mask and a free-running timestamp into an internal FIFO. Sits directly downstream of the signal-producing logic in the event-region test modules. Turns signal activity into an ordered, clock-aligned event stream that a monitor or scoreboard drains over a valid/ready interface.

---
 rtl/evt_pkg.sv | 25 ++
 rtl/evt_change_logger_if.sv | 37 +++
 rtl/evt_fifo.sv | 58 +++++
 rtl/evt_change_logger.sv | 97 +++++++++
 4 files changed

// File: rtl/evt_pkg.sv
// ============================================================================
// evt_pkg : shared types and constants for the change-event logger
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package evt_pkg;

  localparam int EVT_WIDTH  = 4;
  localparam int EVT_TS_W   = 16;
  localparam int DROP_CNT_W = 8;

  typedef struct packed {
    logic [EVT_WIDTH-1:0] sig;
    logic [EVT_WIDTH-1:0] mask;
    logic [EVT_TS_W-1:0]  ts;
  } evt_entry_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/evt_change_logger_if.sv
// ============================================================================
// evt_change_logger_if : monitored inputs, event stream and drop status
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface evt_change_logger_if
  import evt_pkg::*;
#(
  parameter int WIDTH = EVT_WIDTH,
  parameter int TS_W  = EVT_TS_W
);

  logic                  enable;
  logic [WIDTH-1:0]      sig_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_sig;
  logic [WIDTH-1:0]      out_mask;
  logic [TS_W-1:0]       out_ts;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  clr_ovf;

  modport master (
    input  enable, sig_in, out_ready, clr_ovf,
    output out_valid, out_sig, out_mask, out_ts, overflow, drop_cnt
  );

  modport slave (
    output enable, sig_in, out_ready, clr_ovf,
    input  out_valid, out_sig, out_mask, out_ts, overflow, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/evt_fifo.sv
// ============================================================================
// evt_fifo : first-word-fall-through synchronous FIFO with wrap-bit pointers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module evt_fifo
  import evt_pkg::*;
#(
  parameter type T     = evt_entry_t,
  parameter int  DEPTH = 8
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  push,
  input  T     data_in,
  output logic full,
  input  wire  pop,
  output T     data_out,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];
  T            held;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      held   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (!empty)  held   <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // An empty FIFO keeps presenting the last head it showed.
  assign data_out = empty ? held : mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/evt_change_logger.sv
// ============================================================================
// evt_change_logger : logs timestamped bit-change events of a signal bus
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module evt_change_logger
  import evt_pkg::*;
#(
  parameter int WIDTH = EVT_WIDTH,
  parameter int TS_W  = EVT_TS_W,
  parameter int DEPTH = 8
) (
  input wire                  clk,
  input wire                  rst_n,
  evt_change_logger_if.master bus
);

  typedef struct packed {
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] mask;
    logic [TS_W-1:0]  ts;
  } entry_t;

  logic [TS_W-1:0]       ts_cnt;
  logic [WIDTH-1:0]      prev;
  logic                  armed;
  logic [WIDTH-1:0]      mask;
  logic                  evt;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  full;
  logic                  empty;
  logic                  ovf_flag;
  logic [DROP_CNT_W-1:0] drop_count;
  entry_t                wr_entry;
  entry_t                head;

  assign mask = bus.sig_in ^ prev;
  assign evt  = armed & bus.enable & (|mask);
  assign pop  = ~empty & bus.out_ready;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the event.
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  assign wr_entry = '{sig: bus.sig_in, mask: mask, ts: ts_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      prev   <= '0;
      armed  <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      prev   <= bus.sig_in;
      armed  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      ovf_flag   <= 1'b1;
      drop_count <= bus.clr_ovf ? DROP_CNT_W'(1) : sat_inc(drop_count);
    end else if (bus.clr_ovf) begin
      ovf_flag   <= 1'b0;
      drop_count <= '0;
    end
  end

  evt_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .data_in  (wr_entry),
    .full     (full),
    .pop      (pop),
    .data_out (head),
    .empty    (empty)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_sig   = head.sig;
  assign bus.out_mask  = head.mask;
  assign bus.out_ts    = head.ts;
  assign bus.overflow  = ovf_flag;
  assign bus.drop_cnt  = drop_count;

endmodule

`default_nettype wire
